// File: rtl/route_reserve_arbiter.sv
// Per-output route reservation for a wormhole router: each output has its own
// round-robin arbiter and is held by one input from grant until that input's release.
module route_reserve_arbiter #(
  parameter int N_PORTS       = 4,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_PORTS-1:0]                 routeReserveRequestValid,
  input  logic [N_PORTS*REQUEST_WIDTH-1:0]   routeReserveRequest,
  input  logic [N_PORTS-1:0]                 routeRelease,
  output logic [N_PORTS-1:0]                 routeReserveStatus,
  output logic [N_PORTS*REQUEST_WIDTH-1:0]   outputOwner,
  output logic [N_PORTS-1:0]                 outputBusy,
  output logic                               badRequest
);

  typedef logic [REQUEST_WIDTH-1:0] portIdx_t;
  typedef enum logic {
    IDLE     = 1'b0,
    RESERVED = 1'b1
  } outState_t;

  outState_t            state     [N_PORTS];
  outState_t            stateNext [N_PORTS];
  portIdx_t             owner     [N_PORTS];
  portIdx_t             ownerNext [N_PORTS];
  portIdx_t             rrPtr     [N_PORTS];
  portIdx_t             rrPtrNext [N_PORTS];
  portIdx_t             reqIdx    [N_PORTS];
  logic [N_PORTS-1:0]   eligible  [N_PORTS];
  logic [N_PORTS-1:0]   ownsAny;
  logic [N_PORTS-1:0]   statusNext;
  logic                 badNext;
  logic                 found;
  portIdx_t             cand;

  always_comb begin
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      reqIdx[i] = routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH];
    end
  end

  always_comb begin
    ownsAny = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      for (int unsigned o = 0; o < N_PORTS; o++) begin
        if (state[o] == RESERVED && owner[o] == portIdx_t'(i)) begin
          ownsAny[i] = 1'b1;
        end
      end
    end
  end

  // An input already holding an output, or still showing its grant pulse, cannot win again.
  always_comb begin
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        eligible[o][i] = routeReserveRequestValid[i] && (reqIdx[i] == portIdx_t'(o)) &&
                         !ownsAny[i] && !routeReserveStatus[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned o = 0; o < N_PORTS; o++) begin
        state[o] <= IDLE;
        owner[o] <= '0;
        rrPtr[o] <= portIdx_t'(N_PORTS - 1);
      end
      routeReserveStatus <= '0;
      badRequest         <= 1'b0;
    end else begin
      for (int unsigned o = 0; o < N_PORTS; o++) begin
        state[o] <= stateNext[o];
        owner[o] <= ownerNext[o];
        rrPtr[o] <= rrPtrNext[o];
      end
      routeReserveStatus <= statusNext;
      badRequest         <= badNext;
    end
  end

  always_comb begin
    statusNext = '0;
    found      = 1'b0;
    cand       = '0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      stateNext[o] = state[o];
      ownerNext[o] = owner[o];
      rrPtrNext[o] = rrPtr[o];
      found        = 1'b0;
      unique case (state[o])
        IDLE: begin
          // Scan starts just after the last winner so it becomes lowest priority.
          for (int unsigned k = 1; k <= N_PORTS; k++) begin
            cand = portIdx_t'((32'(rrPtr[o]) + k) % 32'(N_PORTS));
            if (!found && eligible[o][cand]) begin
              found            = 1'b1;
              stateNext[o]     = RESERVED;
              ownerNext[o]     = cand;
              rrPtrNext[o]     = cand;
              statusNext[cand] = 1'b1;
            end
          end
        end
        RESERVED: begin
          for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (routeRelease[i] && owner[o] == portIdx_t'(i)) begin
              stateNext[o] = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    badNext = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (routeReserveRequestValid[i] &&
          {1'b0, reqIdx[i]} >= (REQUEST_WIDTH + 1)'(N_PORTS)) begin
        badNext = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      outputBusy[o]                                  = (state[o] == RESERVED);
      outputOwner[o*REQUEST_WIDTH +: REQUEST_WIDTH] = owner[o];
    end
  end

endmodule
